// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two write ports, optional forwarding and a busy scoreboard
// Register 0 is hard-wired to zero. Addresses at or above DEPTH read as zero and are never written or marked busy.
module regfile_mp #(
    parameter int WIDTH        = 32,
    parameter int ADRESS_WIDTH = 5,
    parameter int DEPTH        = 32,
    parameter int NUM_RD       = 2,
    parameter int REG_READ     = 0,
    parameter int BYPASS       = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_RD*ADRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*WIDTH-1:0]        rd_dout,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           we0,
    input  logic                           we1,
    input  logic [ADRESS_WIDTH-1:0]        wr_addr0,
    input  logic [ADRESS_WIDTH-1:0]        wr_addr1,
    input  logic [WIDTH-1:0]               wr_din0,
    input  logic [WIDTH-1:0]               wr_din1,
    input  logic                           alloc_valid,
    input  logic [ADRESS_WIDTH-1:0]        alloc_addr
);
    localparam int AW = ADRESS_WIDTH;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wv0;
    logic              wv1;
    logic              av;
    logic [AW-1:0]     ra [NUM_RD];
    logic [WIDTH-1:0]  rd_val [NUM_RD];
    logic [NUM_RD-1:0] busy_c;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < (AW+1)'(DEPTH));
    endfunction

    // Writes and allocations are only real outside reset; this also keeps a reset cycle from forwarding.
    assign wv0 = rst && we0 && addr_ok(wr_addr0);
    assign wv1 = rst && we1 && addr_ok(wr_addr1);
    assign av  = rst && alloc_valid && addr_ok(alloc_addr);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
            busy <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (wv1 && wr_addr1 == AW'(r))
                    mem[r] <= wr_din1;
                else if (wv0 && wr_addr0 == AW'(r))
                    mem[r] <= wr_din0;
                // A new producer claimed in the same cycle outranks the completing write.
                if (av && alloc_addr == AW'(r))
                    busy[r] <= 1'b1;
                else if ((wv0 && wr_addr0 == AW'(r)) || (wv1 && wr_addr1 == AW'(r)))
                    busy[r] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_val[k] = '0;
            busy_c[k] = 1'b0;
            for (int r = 0; r < DEPTH; r++) begin
                if (ra[k] == AW'(r)) begin
                    rd_val[k] = mem[r];
                    busy_c[k] = busy[r];
                end
            end
            if (BYPASS != 0) begin
                if (wv1 && wr_addr1 == ra[k]) begin
                    rd_val[k] = wr_din1;
                    busy_c[k] = 1'b0;
                end else if (wv0 && wr_addr0 == ra[k]) begin
                    rd_val[k] = wr_din0;
                    busy_c[k] = 1'b0;
                end
            end
        end
    end

    assign rd_busy = busy_c;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign ra[k] = rd_addr[k*AW +: AW];
        if (REG_READ != 0) begin : g_reg
            logic [WIDTH-1:0] q;
            always_ff @(posedge clk) begin
                if (!rst) q <= '0;
                else      q <= rd_val[k];
            end
            assign rd_dout[k*WIDTH +: WIDTH] = q;
        end else begin : g_comb
            assign rd_dout[k*WIDTH +: WIDTH] = rd_val[k];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (combinational+bypass and registered+no-bypass builds)
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic        we0, we1, alloc_valid;
    logic [4:0]  wr_addr0, wr_addr1, alloc_addr;
    logic [31:0] wr_din0, wr_din1;
    logic [63:0] a_dout, b_dout;
    logic [1:0]  a_busy, b_busy;

    int passed = 0;
    int total  = 0;
    bit checking = 1'b0;

    // Reference state: register contents, busy bits, and the registered read outputs of build B.
    logic [31:0] m_mem [32];
    logic        m_busy [32];
    logic [31:0] b_q [2];

    localparam int B_DEPTH = 24;

    always #5 clk = ~clk;

    regfile_mp #(.WIDTH(32), .ADRESS_WIDTH(5), .DEPTH(32), .NUM_RD(2), .REG_READ(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(a_dout), .rd_busy(a_busy),
        .we0(we0), .we1(we1), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_din0(wr_din0), .wr_din1(wr_din1), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr));

    regfile_mp #(.WIDTH(32), .ADRESS_WIDTH(5), .DEPTH(B_DEPTH), .NUM_RD(2), .REG_READ(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_dout(b_dout), .rd_busy(b_busy),
        .we0(we0), .we1(we1), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1),
        .wr_din0(wr_din0), .wr_din1(wr_din1), .alloc_valid(alloc_valid), .alloc_addr(alloc_addr));

    function automatic bit wr_ok(bit we, int a, int depth);
        return rst && we && a != 0 && a < depth;
    endfunction

    function automatic logic [31:0] exp_rd(int a, bit byp, int depth);
        if (a == 0 || a >= depth) return 32'h0;
        if (byp && wr_ok(we1, wr_addr1, depth) && wr_addr1 == a) return wr_din1;
        if (byp && wr_ok(we0, wr_addr0, depth) && wr_addr0 == a) return wr_din0;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(int a, bit byp, int depth);
        if (a == 0 || a >= depth) return 1'b0;
        if (byp && ((wr_ok(we1, wr_addr1, depth) && wr_addr1 == a) ||
                    (wr_ok(we0, wr_addr0, depth) && wr_addr0 == a))) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            int a;
            a = int'(rd_addr[k*5 +: 5]);
            chk($sformatf("a_dout%0d@%0d", k, a), a_dout[k*32 +: 32], exp_rd(a, 1'b1, 32));
            chk($sformatf("a_busy%0d@%0d", k, a), 32'(a_busy[k]), 32'(exp_busy(a, 1'b1, 32)));
            chk($sformatf("b_dout%0d", k), b_dout[k*32 +: 32], b_q[k]);
            chk($sformatf("b_busy%0d@%0d", k, a), 32'(b_busy[k]), 32'(exp_busy(a, 1'b0, B_DEPTH)));
        end
    endtask

    // Apply the rules of one rising edge to the reference state, using the inputs held during the cycle.
    task automatic model_edge();
        if (!rst) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[r]  = 32'h0;
                m_busy[r] = 1'b0;
            end
            b_q[0] = 32'h0;
            b_q[1] = 32'h0;
        end else begin
            b_q[0] = exp_rd(int'(rd_addr[4:0]), 1'b0, B_DEPTH);
            b_q[1] = exp_rd(int'(rd_addr[9:5]), 1'b0, B_DEPTH);
            if (wr_ok(we0, wr_addr0, 32)) begin m_mem[wr_addr0] = wr_din0; m_busy[wr_addr0] = 1'b0; end
            if (wr_ok(we1, wr_addr1, 32)) begin m_mem[wr_addr1] = wr_din1; m_busy[wr_addr1] = 1'b0; end
            if (alloc_valid && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
    endtask

    task automatic cycle();
        #1;
        if (checking) check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; alloc_valid = 0;
        wr_addr0 = 0; wr_addr1 = 0; alloc_addr = 0;
        wr_din0 = 0; wr_din1 = 0;
    endtask

    task automatic set_rd(int a0, int a1);
        rd_addr = {5'(a1), 5'(a0)};
    endtask

    task automatic wr0(int a, logic [31:0] d);
        we0 = 1; wr_addr0 = 5'(a); wr_din0 = d;
    endtask

    task automatic wr1(int a, logic [31:0] d);
        we1 = 1; wr_addr1 = 5'(a); wr_din1 = d;
    endtask

    initial begin
        rst = 0; idle(); set_rd(0, 0);
        cycle();
        rst = 1; checking = 1;
        cycle();

        // Single write then read back.
        wr0(5, 32'hDEADBEEF); cycle();
        idle(); set_rd(5, 0); #1;
        chk("wr_rd_5", a_dout[31:0], 32'hDEADBEEF);
        chk("rd_zero", a_dout[63:32], 32'h0);
        cycle();

        // Dual write to one address and a write to register 0.
        wr0(3, 32'h11); wr1(3, 32'h22); cycle();
        idle(); wr0(0, 32'hFF); set_rd(3, 0); #1;
        chk("port1_prio", a_dout[31:0], 32'h22);
        chk("reg0_zero", a_dout[63:32], 32'h0);
        cycle();

        // Same-cycle forwarding vs pre-write value.
        idle(); wr0(7, 32'h1111); cycle();
        idle(); wr1(7, 32'hA5A5); set_rd(7, 7); #1;
        chk("bypass_a", a_dout[31:0], 32'hA5A5);
        cycle();
        idle(); #1;
        chk("nobypass_b", b_dout[31:0], 32'h1111);
        cycle();

        // Registered read latency and hold.
        wr0(9, 32'h1234); cycle();
        idle(); set_rd(9, 0); cycle();
        set_rd(1, 0); #1;
        chk("regread_b", b_dout[31:0], 32'h1234);
        cycle();

        // Scoreboard set / alloc-wins / clear.
        idle(); alloc_valid = 1; alloc_addr = 4; cycle();
        idle(); set_rd(4, 0); #1;
        chk("busy_set_a", 32'(a_busy[0]), 32'h1);
        chk("busy_set_b", 32'(b_busy[0]), 32'h1);
        alloc_valid = 1; alloc_addr = 4; wr0(4, 32'h44); cycle();
        idle(); #1;
        chk("busy_alloc_wins", 32'(a_busy[0]), 32'h1);
        wr0(4, 32'h45); #1;
        chk("busy_fwd_a", 32'(a_busy[0]), 32'h0);
        chk("busy_nofwd_b", 32'(b_busy[0]), 32'h1);
        cycle();
        idle(); #1;
        chk("busy_clear_b", 32'(b_busy[0]), 32'h0);
        cycle();

        // Fill everything, then reset with a write pending.
        for (int r = 1; r < 32; r++) begin
            idle(); wr0(r, $urandom); alloc_valid = 1; alloc_addr = 5'(r); set_rd(r, 32 - r);
            cycle();
        end
        idle(); rst = 0; wr0(10, 32'hBAD); alloc_valid = 1; alloc_addr = 5'd11; cycle();
        rst = 1; idle();
        for (int r = 0; r < 32; r += 2) begin
            set_rd(r, r + 1); #1;
            chk($sformatf("rst_dout_%0d", r), a_dout[31:0] | a_dout[63:32], 32'h0);
            chk($sformatf("rst_busy_%0d", r), 32'(a_busy | b_busy), 32'h0);
            cycle();
        end

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            we0 = $urandom_range(0, 1); we1 = $urandom_range(0, 1);
            wr_addr0 = 5'($urandom_range(0, 31)); wr_addr1 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) wr_addr1 = wr_addr0;
            wr_din0 = $urandom; wr_din1 = $urandom;
            alloc_valid = $urandom_range(0, 1);
            alloc_addr = ($urandom_range(0, 3) == 0) ? wr_addr0 : 5'($urandom_range(0, 31));
            set_rd(($urandom_range(0, 2) == 0) ? int'(wr_addr1) : $urandom_range(0, 31),
                   ($urandom_range(0, 2) == 0) ? int'(wr_addr0) : $urandom_range(0, 31));
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADRESS_WIDTH, default 5, register address width.
REQ-003 SHALL have parameter DEPTH, default 32, number of registers (DEPTH <= 2**ADRESS_WIDTH).
REQ-004 SHALL have parameter NUM_RD, default 2, number of read ports (1..4).
REQ-005 SHALL have parameter REG_READ, default 0; 0 = combinational read, 1 = registered read.
REQ-006 SHALL have parameter BYPASS, default 1; 1 = same-cycle write-to-read forwarding enabled.
REQ-007 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-009 SHALL have port rd_addr  input  NUM_RD*ADRESS_WIDTH  packed read addresses, port k at slice k.
REQ-010 SHALL have port rd_dout  output  NUM_RD*WIDTH  packed read data, port k at slice k.
REQ-011 SHALL have port rd_busy  output  NUM_RD  scoreboard busy flag for each read port's address.
REQ-012 SHALL have ports we0/we1  input  1 each  write enables, write ports 0 and 1.
REQ-013 SHALL have ports wr_addr0/wr_addr1  input  ADRESS_WIDTH each  write addresses.
REQ-014 SHALL have ports wr_din0/wr_din1  input  WIDTH each  write data.
REQ-015 SHALL have port alloc_valid  input  1  marks a destination register as pending (issue).
REQ-016 SHALL have port alloc_addr  input  ADRESS_WIDTH  register being allocated.

Function
REQ-017 Write port p SHALL update register wr_addrp at rising edge when wep=1, wr_addrp!=0 and wr_addrp<DEPTH; otherwise no update.
REQ-018 Both ports writing the same valid address in one cycle SHALL store wr_din1 (port 1 priority).
REQ-019 Register 0 SHALL always read 0 and never be written or marked busy.
REQ-020 Read of address >= DEPTH SHALL return 0 with rd_busy=0.
REQ-021 REG_READ=0: rd_dout[k] SHALL be combinational from rd_addr[k], zero latency.
REQ-022 REG_READ=1: rd_dout[k] SHALL be captured at the rising edge from the rd_addr[k] presented that cycle, latency 1, held otherwise.
REQ-023 BYPASS=1: a read whose address matches an enabled valid write in the same cycle SHALL return that write data (port 1 over port 0), in either REG_READ mode.
REQ-024 BYPASS=0: same-cycle read SHALL return the pre-write array value (REG_READ=0) or the pre-write value captured (REG_READ=1).
REQ-025 Scoreboard: busy[r] SHALL set at edge when alloc_valid=1, alloc_addr=r, r!=0, r<DEPTH.
REQ-026 busy[r] SHALL clear at edge when any valid write targets r and no allocation of r occurs that cycle.
REQ-027 Simultaneous alloc and write to same r SHALL leave busy[r]=1 (new producer wins); data still written.
REQ-028 rd_busy[k] SHALL equal busy[rd_addr[k]], forced 0 when BYPASS=1 and a same-cycle write to that address is forwarded; combinational in both REG_READ modes.

Reset
REQ-029 rst=0 at a rising edge SHALL clear all registers, all busy bits and (REG_READ=1) all rd_dout to 0.
REQ-030 Writes and allocations presented during a reset cycle SHALL be ignored; operation resumes first edge with rst=1.
REQ-031 Reset asserted mid-operation SHALL discard pending busy state without completing writes.

Verification
REQ-032 Reset, then we0=1 addr 5 din 0xDEADBEEF; next cycle rd_addr0=5 -> rd_dout0=0xDEADBEEF; rd_addr1=0 -> 0.
REQ-033 we0 addr 3 din 0x11, we1 addr 3 din 0x22 same cycle -> reg 3 = 0x22; we0 addr 0 din 0xFF -> reg 0 reads 0.
REQ-034 BYPASS=1, REG_READ=0: we1 addr 7 din 0xA5A5 with rd_addr0=7 same cycle -> rd_dout0=0xA5A5 that cycle; BYPASS=0 -> old value.
REQ-035 REG_READ=1: rd_addr0=9 (reg 9=0x1234) at edge N -> rd_dout0=0x1234 after edge N, unchanged until next edge.
REQ-036 alloc 4 -> rd_busy=1 for addr 4; alloc 4 + we0 addr 4 same cycle -> busy stays 1; later we0 addr 4 -> busy 0.
REQ-037 Load regs 1..31 and busy bits, rst=0 one cycle with we0=1 -> all reads 0, all rd_busy 0, write not applied.
